// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Handles the hazards that bypassing cannot cover:
//   - load-use
//   - MUL/DIV occupancy of EX
//   - taken branches
//   - interrupt entry
//
// Ports:
//   clk, reset          pipeline clock, asynchronous active-high reset
//   intterupt           external interrupt request (level)
//   rsaddrID, rtaddrID  source register fields of the ID instruction
//   regwriteaddrEX      destination register of the EX instruction
//   MemReadEX           EX instruction is a load
//   MulDivStartEX       EX instruction is MUL/DIV, first EX cycle
//   BranchTakenEX       branch/jump in EX resolved taken
//   PCWrite, IFIDWrite, IDEXWrite    register write enables
//   IFIDFlush, IDEXFlush, EXMEMFlush bubble/flush controls
//   IntTaken            one-cycle pulse, PC loads the exception vector
//   mdbusy              MUL/DIV is occupying EX
//   stallcount          (only with HAZARD_STALLCNT_EN) count of PC-frozen cycles
//
// Optional feature macro: HAZARD_STALLCNT_EN adds the 32-bit stallcount output.
//
// Outputs are combinational from state and inputs so that stalls take effect
// in the same cycle the hazard is seen.
module hazard_stall_ctrl #(
    parameter int unsigned MD_CYCLES = 4,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intterupt,
    input  logic [4:0] rsaddrID,
    input  logic [4:0] rtaddrID,
    input  logic [4:0] regwriteaddrEX,
    input  logic       MemReadEX,
    input  logic       MulDivStartEX,
    input  logic       BranchTakenEX,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEXWrite,
    output logic       IFIDFlush,
    output logic       IDEXFlush,
    output logic       EXMEMFlush,
    output logic       IntTaken,
    output logic       mdbusy
`ifdef HAZARD_STALLCNT_EN
    ,
    output logic [31:0] stallcount
`endif
);

    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDBUSY   = 2'd1,
        ST_INTFLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic             intpending;
    logic             intpending_nx;
    logic             load_use;

    // Register 0 is hardwired to zero, so a load targeting it never stalls.
    assign load_use = MemReadEX && (regwriteaddrEX != REG_W'(0)) &&
                      ((regwriteaddrEX == rsaddrID) || (regwriteaddrEX == rtaddrID));

    // State, counter and pending-interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            count      <= '0;
            intpending <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            intpending <= intpending_nx;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        IntTaken   = 1'b0;
        mdbusy     = 1'b0;

        // A request arriving while one is pending merges into it; the
        // request is retired on the edge leaving INTFLUSH.
        if (state == ST_INTFLUSH) begin
            intpending_nx = 1'b0;
        end else begin
            intpending_nx = intpending | intterupt;
        end

        case (state)
            ST_RUN: begin
                if (intpending) begin
                    // Freeze the front end; the EX instruction completes.
                    state_nx  = ST_INTFLUSH;
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end else if (MulDivStartEX) begin
                    state_nx   = ST_MDBUSY;
                    count_nx   = MD_LOAD;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    EXMEMFlush = 1'b1;
                    mdbusy     = 1'b1;
                end else if (BranchTakenEX) begin
                    // ID holds a wrong-path instruction, so any load-use match is moot.
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end else if (load_use) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
            end

            ST_MDBUSY: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMFlush = 1'b1;
                mdbusy     = 1'b1;
                count_nx   = count - CNT_W'(1);
                // Last busy cycle: let the result through into EX/MEM.
                // The <= also guards against a stuck counter at zero.
                if (count <= CNT_W'(1)) begin
                    state_nx   = ST_RUN;
                    EXMEMFlush = 1'b0;
                    count_nx   = '0;
                end
            end

            ST_INTFLUSH: begin
                state_nx  = ST_RUN;
                IntTaken  = 1'b1;
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end

            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

`ifdef HAZARD_STALLCNT_EN
    // Counts every cycle in which the PC is held; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcount <= '0;
        end else if (!PCWrite) begin
            stallcount <= stallcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: table of single-cycle RUN-state vectors, then
// hand-written multi-cycle sequences (MUL/DIV, interrupts, reset mid-MDBUSY).
// Expected output words are queued when stimulus is driven and popped when
// the outputs are sampled, just before the next rising edge.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       intterupt;
    logic [4:0] rsaddrID;
    logic [4:0] rtaddrID;
    logic [4:0] regwriteaddrEX;
    logic       MemReadEX;
    logic       MulDivStartEX;
    logic       BranchTakenEX;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXWrite;
    logic       IFIDFlush;
    logic       IDEXFlush;
    logic       EXMEMFlush;
    logic       IntTaken;
    logic       mdbusy;
`ifdef HAZARD_STALLCNT_EN
    logic [31:0] stallcount;
`endif

    hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .intterupt     (intterupt),
        .rsaddrID      (rsaddrID),
        .rtaddrID      (rtaddrID),
        .regwriteaddrEX(regwriteaddrEX),
        .MemReadEX     (MemReadEX),
        .MulDivStartEX (MulDivStartEX),
        .BranchTakenEX (BranchTakenEX),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEXWrite     (IDEXWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXFlush     (IDEXFlush),
        .EXMEMFlush    (EXMEMFlush),
        .IntTaken      (IntTaken),
        .mdbusy        (mdbusy)
`ifdef HAZARD_STALLCNT_EN
        ,
        .stallcount    (stallcount)
`endif
    );

    always #5 clk = ~clk;

    // Output word: {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXFlush,EXMEMFlush,IntTaken,mdbusy}
    localparam logic [7:0] O_DEF   = 8'b1110_0000; // defaults
    localparam logic [7:0] O_FRZ   = 8'b0010_1000; // load-use bubble / interrupt freeze
    localparam logic [7:0] O_BR    = 8'b1111_1000; // taken-branch flush
    localparam logic [7:0] O_MD    = 8'b0000_0101; // MUL/DIV busy, result held back
    localparam logic [7:0] O_MDEND = 8'b0000_0001; // last MUL/DIV cycle
    localparam logic [7:0] O_INT   = 8'b1111_1010; // interrupt entry

    typedef struct {
        logic       intr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       memread;
        logic       mdstart;
        logic       brtaken;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
        string      name;
    } vec_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] exp_stall   = 32'd0;
    vec_t        tbl[10];

    function automatic in_t mk(input logic intr, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic memread,
                               input logic mdstart, input logic brtaken);
        in_t r;
        r.intr = intr; r.rs = rs; r.rt = rt; r.rd = rd;
        r.memread = memread; r.mdstart = mdstart; r.brtaken = brtaken;
        return r;
    endfunction

    function automatic logic [7:0] outs();
        return {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, IntTaken, mdbusy};
    endfunction

    task automatic drive(input in_t in);
        intterupt      = in.intr;
        rsaddrID       = in.rs;
        rtaddrID       = in.rt;
        regwriteaddrEX = in.rd;
        MemReadEX      = in.memread;
        MulDivStartEX  = in.mdstart;
        BranchTakenEX  = in.brtaken;
    endtask

    task automatic check(input string name);
        logic [7:0] e;
        logic [7:0] got;
        got = outs();
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty, got %b", name, got);
        end else begin
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b", name, got, e);
            end
        end
`ifdef HAZARD_STALLCNT_EN
        vectors++;
        if (stallcount !== exp_stall) begin
            miscompares++;
            $display("FAIL %s stallcount: got %0d expected %0d", name, stallcount, exp_stall);
        end
`endif
    endtask

    // One pipeline cycle: drive after the falling edge, sample before the rising edge.
    task automatic step(input in_t in, input logic [7:0] exp, input string name);
        @(negedge clk);
        drive(in);
        exp_q.push_back(exp);
        #2;
        check(name);
        if (exp[7] == 1'b0) exp_stall = exp_stall + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t idle;
        idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        tbl[0] = '{mk(0, 5'd1,  5'd2,  5'd3,  0, 0, 0), O_DEF, "idle"};
        tbl[1] = '{mk(0, 5'd5,  5'd9,  5'd5,  1, 0, 0), O_FRZ, "loaduse_rs"};
        tbl[2] = '{mk(0, 5'd5,  5'd9,  5'd7,  0, 0, 0), O_DEF, "after_bubble"};
        tbl[3] = '{mk(0, 5'd8,  5'd5,  5'd5,  1, 0, 0), O_FRZ, "loaduse_rt"};
        tbl[4] = '{mk(0, 5'd0,  5'd0,  5'd0,  1, 0, 0), O_DEF, "load_r0"};
        tbl[5] = '{mk(0, 5'd6,  5'd7,  5'd5,  1, 0, 0), O_DEF, "load_nomatch"};
        tbl[6] = '{mk(0, 5'd5,  5'd5,  5'd5,  0, 0, 0), O_DEF, "alu_match_nostall"};
        tbl[7] = '{mk(0, 5'd5,  5'd1,  5'd5,  1, 0, 1), O_BR,  "branch_over_loaduse"};
        tbl[8] = '{mk(0, 5'd2,  5'd3,  5'd4,  0, 0, 1), O_BR,  "branch_only"};
        tbl[9] = '{mk(0, 5'd0,  5'd31, 5'd31, 1, 0, 0), O_FRZ, "loaduse_r31"};

        // Reset state
        reset = 1'b1;
        drive(idle);
        #1;
        exp_q.push_back(O_DEF);
        check("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);

        // MUL/DIV: four cycles busy, result released on the fourth.
        // Branch/load-use inputs during MDBUSY must be ignored.
        step(mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_MD,    "md_start");
        step(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_MD,    "md_busy1");
        step(mk(0, 5'd5, 5'd0, 5'd5, 1, 0, 0), O_MD,    "md_busy2");
        step(idle,                             O_MDEND, "md_last");
        step(idle,                             O_DEF,   "md_done");

        // Plain interrupt: seen, freeze, vector, back to normal.
        step(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_DEF, "int_seen");
        step(idle,                             O_FRZ, "int_freeze");
        step(idle,                             O_INT, "int_taken");
        step(idle,                             O_DEF, "int_after");

        // Pending interrupt outranks a MUL/DIV start.
        step(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_DEF, "int2_seen");
        step(mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_FRZ, "int2_over_md");
        step(idle,                             O_INT, "int2_taken");
        step(idle,                             O_DEF, "int2_after");

        // Interrupt during MDBUSY is held until MUL/DIV finishes.
        step(mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_MD,    "mdint_start");
        step(idle,                             O_MD,    "mdint_busy1");
        step(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_MD,    "mdint_busy2_irq");
        step(idle,                             O_MDEND, "mdint_last");
        step(idle,                             O_FRZ,   "mdint_freeze");
        step(idle,                             O_INT,   "mdint_taken");
        step(idle,                             O_DEF,   "mdint_after");

        // Reset mid-MDBUSY with an interrupt pending: both are discarded.
        step(mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_MD, "rst_md_start");
        step(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_MD, "rst_md_busy_irq");
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        exp_stall = 32'd0;
        #1;
        exp_q.push_back(O_DEF);
        check("rst_mid_md");
        @(negedge clk);
        reset = 1'b0;
        step(idle, O_DEF, "rst_after1");
        step(idle, O_DEF, "rst_after2");
        step(idle, O_DEF, "rst_after3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
